// File: rtl/fifo_rd_ctrl_pkg.sv
// ============================================================================
// Module      : fifo_rd_ctrl_pkg
// Description : Shared state encoding and default widths for the FIFO read
//               controller and its pattern checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_ctrl_pkg;

  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_ADDR_SIZE = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_pattern_chk.sv
// ============================================================================
// Module      : fifo_pattern_chk
// Description : Incrementing-pattern checker; counts received words that
//               differ from the expected sequence, saturating.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_pattern_chk
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int CNT_W     = DEF_ADDR_SIZE + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 init_i,
  input  logic [DATA_SIZE-1:0] seed_i,
  input  logic                 valid_i,
  input  logic [DATA_SIZE-1:0] data_i,
  output logic [CNT_W-1:0]     err_count_o
);

  logic [DATA_SIZE-1:0] expected_q, expected_d;
  logic [CNT_W-1:0]     err_q, err_d;

  always_comb begin
    expected_d = expected_q;
    err_d      = err_q;
    if (init_i) begin
      expected_d = seed_i;
      err_d      = '0;
    end else if (valid_i) begin
      expected_d = expected_q + 1'b1;
      if ((data_i != expected_q) && (err_q != {CNT_W{1'b1}})) begin
        err_d = err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      expected_q <= '0;
      err_q      <= '0;
    end else begin
      expected_q <= expected_d;
      err_q      <= err_d;
    end
  end

  assign err_count_o = err_q;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
// ============================================================================
// Module      : fifo_rd_ctrl
// Description : Burst read controller for the read side of a FIFO with
//               one-cycle read latency and incrementing-pattern checking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 start,
  input  logic [ADDR_SIZE:0]   burst_len,
  input  logic [DATA_SIZE-1:0] seed,
  input  logic                 abort,
  input  logic                 r_empty,
  input  logic [DATA_SIZE-1:0] r_data,
  output logic                 r_en,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE:0]   rd_count,
  output logic [ADDR_SIZE:0]   err_count
);

  state_e               state_q, state_d;
  logic [ADDR_SIZE:0]   len_q, len_d;
  logic [ADDR_SIZE:0]   issued_q, issued_d;
  logic [ADDR_SIZE:0]   rd_count_q, rd_count_d;
  logic                 pending_q;
  logic [DATA_SIZE-1:0] out_data_q;
  logic                 accept;

  assign accept = (state_q == ST_IDLE) && start;
  assign r_en   = (state_q == ST_READ) && !r_empty && !abort && (issued_q < len_q);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    rd_count_d = rd_count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d      = burst_len;
          issued_d   = '0;
          rd_count_d = '0;
          state_d    = (burst_len == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (r_en) begin
          issued_d = issued_q + 1'b1;
        end
        if (abort || (issued_d == len_q)) begin
          state_d = ST_DRAIN;
        end
      end
      // Only the read issued in the last READ cycle can still be in flight.
      ST_DRAIN: begin
        if (!pending_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (pending_q) begin
      rd_count_d = rd_count_q + 1'b1;
    end
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      rd_count_q <= '0;
      pending_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      rd_count_q <= rd_count_d;
      pending_q  <= r_en;
      if (pending_q) begin
        out_data_q <= r_data;
      end
    end
  end

  // The word arrives in the strobe cycle; the register holds it afterwards.
  assign out_data  = pending_q ? r_data : out_data_q;
  assign out_valid = pending_q;
  assign busy      = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign rd_count  = rd_count_q;

  fifo_pattern_chk #(
    .DATA_SIZE (DATA_SIZE),
    .CNT_W     (ADDR_SIZE + 1)
  ) u_pattern_chk (
    .clk_i       (r_clk),
    .rst_i       (r_rst),
    .init_i      (accept),
    .seed_i      (seed),
    .valid_i     (pending_q),
    .data_i      (r_data),
    .err_count_o (err_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
// ============================================================================
// Module      : tb_fifo_rd_ctrl
// Description : Scoreboard bench for fifo_rd_ctrl with a behavioural FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_ctrl;

  logic       r_clk = 1'b0;
  logic       r_rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] burst_len = '0;
  logic [7:0] seed = '0;
  logic       abort = 1'b0;
  logic       r_empty;
  logic [7:0] r_data = '0;
  logic       r_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic [4:0] rd_count;
  logic [4:0] err_count;

  fifo_rd_ctrl #(
    .DATA_SIZE (8),
    .ADDR_SIZE (4)
  ) dut (
    .r_clk     (r_clk),
    .r_rst     (r_rst),
    .start     (start),
    .burst_len (burst_len),
    .seed      (seed),
    .abort     (abort),
    .r_empty   (r_empty),
    .r_data    (r_data),
    .r_en      (r_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .rd_count  (rd_count),
    .err_count (err_count)
  );

  always #5 r_clk = ~r_clk;

  // Behavioural FIFO: data appears on r_data the cycle after r_en
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = '0;
  logic [7:0] rd_ptr = '0;
  logic       hold_empty = 1'b0;

  assign r_empty = hold_empty || (wr_ptr == rd_ptr);

  always @(posedge r_clk) begin
    if (r_en) begin
      r_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 8'd1;
    end
  end

  typedef struct {
    int rd;
    int err;
    int ren;
    bit cnt;
  } dexp_t;

  int    chk_cnt  = 0;
  int    pass_cnt = 0;
  int    viol     = 0;
  int    ren_cnt  = 0;
  bit    mon_en   = 1'b1;
  int    exp_q[$];
  dexp_t done_q[$];

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops scoreboard entries when the DUT presents a word or done
  always @(negedge r_clk) begin
    if (mon_en) begin
      if (r_en && r_empty) viol++;
      if (r_en) ren_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
        end else begin
          check("out_data", int'(out_data), exp_q.pop_front());
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          dexp_t d;
          d = done_q.pop_front();
          check("ren_pulses", ren_cnt, d.ren);
          if (d.cnt) begin
            check("rd_count", int'(rd_count), d.rd);
            check("err_count", int'(err_count), d.err);
          end
        end
      end
    end
    if (!busy) ren_cnt = 0;
  end

  task automatic push(input int v);
    mem[wr_ptr] = 8'(v);
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic do_start(input int len, input int sd);
    tick();
    start     = 1'b1;
    burst_len = 5'(len);
    seed      = 8'(sd);
    tick();
    start = 1'b0;
  endtask

  task automatic expect_done(input int rd, input int err, input int ren, input bit cnt);
    dexp_t d;
    d.rd = rd; d.err = err; d.ren = ren; d.cnt = cnt;
    done_q.push_back(d);
  endtask

  task automatic sb_check(input string name);
    check({name, "_words_left"}, exp_q.size(), 0);
    check({name, "_done_left"}, done_q.size(), 0);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      chk_cnt++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
    end
    tick();
    sb_check(name);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ren", int'(r_en), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_rd_count", int'(rd_count), 0);
    check("rst_err_count", int'(err_count), 0);
    r_rst = 1'b0;
    tick();

    // Eight pre-filled words 0x00..0x07
    for (int i = 0; i < 8; i++) begin
      push(i);
      exp_q.push_back(i);
    end
    expect_done(8, 0, 8, 1'b1);
    do_start(8, 8'h00);
    check("busy_in_read", int'(busy), 1);
    wait_done("burst8", 40);

    // Empty for five cycles, then three words
    hold_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(8'h20 + i);
      exp_q.push_back(8'h20 + i);
    end
    expect_done(3, 0, 3, 1'b1);
    do_start(3, 8'h20);
    for (int i = 0; i < 5; i++) begin
      check("ren_while_empty", int'(r_en), 0);
      tick();
    end
    hold_empty = 1'b0;
    wait_done("stall", 30);

    // Pattern errors on words 2 and 3
    push(8'h10); push(8'h11); push(8'h13); push(8'h14);
    exp_q.push_back(8'h10); exp_q.push_back(8'h11);
    exp_q.push_back(8'h13); exp_q.push_back(8'h14);
    expect_done(4, 2, 4, 1'b1);
    do_start(4, 8'h10);
    wait_done("pattern", 30);

    // Abort after two reads of a six-word burst
    push(8'h30); push(8'h31);
    exp_q.push_back(8'h30); exp_q.push_back(8'h31);
    expect_done(2, 0, 2, 1'b1);
    do_start(6, 8'h30);
    repeat (4) tick();
    abort = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h32 + i);
    tick();
    abort = 1'b0;
    wait_done("abort", 20);
    wr_ptr = rd_ptr;

    // Zero-length burst: done on the next cycle, no reads
    expect_done(0, 0, 0, 1'b0);
    push(8'h77);
    tick();
    start = 1'b1; burst_len = 5'd0; seed = 8'h00;
    tick();
    start = 1'b0;
    check("len0_done", int'(done), 1);
    check("len0_ren", int'(r_en), 0);
    tick();
    check("len0_done_one_cycle", int'(done), 0);
    sb_check("len0");
    wr_ptr = rd_ptr;

    // A start while busy is ignored
    for (int i = 0; i < 4; i++) begin
      push(8'h40 + i);
      exp_q.push_back(8'h40 + i);
    end
    expect_done(4, 0, 4, 1'b1);
    do_start(4, 8'h40);
    start = 1'b1; burst_len = 5'd2; seed = 8'h99;
    tick();
    start = 1'b0;
    wait_done("busy_start", 30);

    // Reset mid-burst
    mon_en = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h60 + i);
    do_start(8, 8'h60);
    repeat (2) tick();
    r_rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ren", int'(r_en), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_rd_count", int'(rd_count), 0);
    check("mid_rst_err_count", int'(err_count), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    repeat (2) tick();
    r_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_ren", int'(r_en), 0);
    end
    wr_ptr = rd_ptr;
    exp_q.delete();
    done_q.delete();
    tick();
    mon_en = 1'b1;

    // Recovery burst after reset
    push(8'h50); push(8'h51);
    exp_q.push_back(8'h50); exp_q.push_back(8'h51);
    expect_done(2, 0, 2, 1'b1);
    do_start(2, 8'h50);
    wait_done("recover", 20);

    check("ren_while_empty_total", viol, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
